rvv_wb_collector: RTL and testbench

Vector writeback collector sitting downstream of the per-lane RVV ALU array. It captures per-lane result chunks (data, bit index, valid), merges them into a VLEN-bit destination image seeded with the old destination value, and preserves tail (and optionally masked-off) elements. When the ALU array signals completion, it presents the assembled register to the vector register file over a valid/ready handshake.

---
 rtl/rvv_wb_collector.sv | 123 ++++++++++++
 tb/tb_rvv_wb_collector.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rvv_wb_collector.sv
// rvv_wb_collector: merges per-lane ALU result chunks into a VLEN-bit image seeded with vd_old
// and hands it to the register file. RVV_WB_MASK_EN adds vm/v0 mask-undisturbed filtering.
module rvv_wb_collector #(
   parameter int VLEN       = 128,
   parameter int LANE_WIDTH = 3,
   parameter int NB_LANES   = 1
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         start,
   input  logic [4:0]                   vd_addr,
   input  logic [VLEN-1:0]              vd_old,
   input  logic [2:0]                   vsew,
   input  logic [10:0]                  vl,
`ifdef RVV_WB_MASK_EN
   input  logic                         vm,
   input  logic [VLEN-1:0]              v0,
`endif
   input  logic [64*(1<<NB_LANES)-1:0]  lane_data,
   input  logic [10*(1<<NB_LANES)-1:0]  lane_index,
   input  logic [(1<<NB_LANES)-1:0]     lane_valid,
   input  logic                         alu_done,
   output logic                         wb_valid,
   input  logic                         wb_ready,
   output logic [4:0]                   wb_addr,
   output logic [VLEN-1:0]              wb_data,
   output logic [9:0]                   chunk_cnt,
   output logic                         busy
);
   localparam int W = 1 << LANE_WIDTH;
   localparam int L = 1 << NB_LANES;

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;
   state_t state, state_n;

   logic [VLEN-1:0] img, img_n;
   logic [9:0]      cnt_n;
   logic [4:0]      addr_q;
   logic [2:0]      vsew_q;
   logic [10:0]     vl_q;
   logic [9:0]      idx  [L];
   logic [9:0]      elem [L];
   logic [L-1:0]    hit;
   logic [L*(64-W)-1:0] lane_hi;
   logic            unused_lane_hi;
`ifdef RVV_WB_MASK_EN
   logic            vm_q;
   logic [VLEN-1:0] v0_q;
`endif

   always_ff @(posedge clk) state <= !resetn ? IDLE : state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = COLLECT;
         COLLECT: if (alu_done) state_n = WRITE;
         WRITE:   if (wb_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   for (genvar g = 0; g < L; g++) begin : g_lane
      logic en;
      assign idx[g]  = {lane_index[g*10+LANE_WIDTH +: 10-LANE_WIDTH], {LANE_WIDTH{1'b0}}};
      assign elem[g] = idx[g] >> ({1'b0, vsew_q} + 4'd3);
`ifdef RVV_WB_MASK_EN
      logic [VLEN-1:0] v0_sh;
      assign v0_sh = v0_q >> elem[g];
      assign en    = vm_q | v0_sh[0];
`else
      assign en = 1'b1;
`endif
      assign hit[g] = lane_valid[g] && ({1'b0, elem[g]} < vl_q) &&
                      (32'(idx[g]) + 32'(W) <= 32'(VLEN)) && en;
      assign lane_hi[g*(64-W) +: 64-W] = lane_data[g*64+W +: 64-W];
   end
   assign unused_lane_hi = ^lane_hi;

   // Ascending lane order lets the higher lane overwrite on a shared offset.
   always_comb begin
      img_n = img;
      cnt_n = chunk_cnt;
      for (int i = 0; i < L; i++)
         if (hit[i]) begin
            img_n = (img_n & ~({{(VLEN-W){1'b0}}, {W{1'b1}}} << idx[i])) |
                    ({{(VLEN-W){1'b0}}, lane_data[i*64 +: W]} << idx[i]);
            cnt_n = cnt_n + 10'd1;
         end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         img       <= '0;
         addr_q    <= '0;
         chunk_cnt <= '0;
         vsew_q    <= '0;
         vl_q      <= '0;
`ifdef RVV_WB_MASK_EN
         vm_q      <= 1'b1;
         v0_q      <= '0;
`endif
      end else if (state == IDLE && start) begin
         img       <= vd_old;
         addr_q    <= vd_addr;
         chunk_cnt <= '0;
         vsew_q    <= vsew;
         vl_q      <= vl;
`ifdef RVV_WB_MASK_EN
         vm_q      <= vm;
         v0_q      <= v0;
`endif
      end else if (state == COLLECT) begin
         img       <= img_n;
         chunk_cnt <= cnt_n;
      end
   end

   assign wb_valid = state == WRITE;
   assign busy     = state != IDLE;
   assign wb_data  = img;
   assign wb_addr  = addr_q;
endmodule

// File: tb/tb_rvv_wb_collector.sv
// tb_rvv_wb_collector: directed table of full instructions plus hand-written corner sequences.
// Define RVV_WB_MASK_EN for both DUT and bench to exercise the mask build.
module tb_rvv_wb_collector;
   logic         clk = 1'b0;
   logic         resetn, start, alu_done, wb_ready, wb_valid, busy, vm;
   logic [4:0]   vd_addr, wb_addr;
   logic [127:0] vd_old, wb_data, v0;
   logic [2:0]   vsew;
   logic [10:0]  vl;
   logic [127:0] lane_data;
   logic [19:0]  lane_index;
   logic [1:0]   lane_valid;
   logic [9:0]   chunk_cnt;
   int           total = 0, bad = 0;

   always #5 clk = ~clk;

   rvv_wb_collector dut (
      .clk(clk), .resetn(resetn), .start(start), .vd_addr(vd_addr), .vd_old(vd_old),
      .vsew(vsew), .vl(vl),
`ifdef RVV_WB_MASK_EN
      .vm(vm), .v0(v0),
`endif
      .lane_data(lane_data), .lane_index(lane_index), .lane_valid(lane_valid),
      .alu_done(alu_done), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
      .wb_data(wb_data), .chunk_cnt(chunk_cnt), .busy(busy)
   );

   typedef struct {
      string        name;
      logic [2:0]   vsew;
      logic [10:0]  vl;
      logic [7:0]   old;
      logic [7:0]   base;
      logic         vm;
      logic [127:0] v0;
      logic [127:0] exp;
      logic [9:0]   cnt;
   } vec_t;

   vec_t vt [$];

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic lanes(input logic [1:0] v, input logic [9:0] i0, input logic [9:0] i1,
                        input logic [7:0] d0, input logic [7:0] d1);
      lane_valid = v;
      lane_index = {i1, i0};
      lane_data  = {56'hDEAD_BEEF_0000_00, d1, 56'hFFFF_FFFF_FFFF_FF, d0};
   endtask

   // Lane pairs cover byte offsets 0..15 over 8 cycles; alu_done rides with the last pair.
   task automatic run_vec(input vec_t v);
      start = 1'b1; vd_addr = 5'd17; vd_old = {16{v.old}}; vsew = v.vsew; vl = v.vl;
      vm = v.vm; v0 = v.v0;
      step();
      start = 1'b0; vd_old = '0;
      chk({v.name, " busy"}, 128'(busy), 128'd1);
      for (int c = 0; c < 8; c++) begin
         lanes(2'b11, 10'(16*c), 10'(16*c+8), 8'(v.base + 8'(2*c)), 8'(v.base + 8'(2*c+1)));
         alu_done = (c == 7);
         step();
         if (c < 7) chk({v.name, " early_valid"}, 128'(wb_valid), 128'd0);
      end
      lane_valid = '0; alu_done = 1'b0;
      chk({v.name, " wb_valid"}, 128'(wb_valid), 128'd1);
      chk({v.name, " wb_data"}, wb_data, v.exp);
      chk({v.name, " chunk_cnt"}, 128'(chunk_cnt), 128'(v.cnt));
      chk({v.name, " wb_addr"}, 128'(wb_addr), 128'd17);
      wb_ready = 1'b1;
      step();
      wb_ready = 1'b0;
      chk({v.name, " idle_valid"}, 128'(wb_valid), 128'd0);
      chk({v.name, " idle_busy"}, 128'(busy), 128'd0);
   endtask

   initial begin
      vt.push_back('{"sew8_full", 3'd0, 11'd16, 8'hAA, 8'h00, 1'b1, '0,
                     128'h0F0E0D0C0B0A09080706050403020100, 10'd16});
      vt.push_back('{"sew8_tail", 3'd0, 11'd5, 8'hAA, 8'h00, 1'b1, '0,
                     128'hAAAAAAAAAAAAAAAAAAAAAA0403020100, 10'd5});
      vt.push_back('{"sew32_full", 3'd2, 11'd4, 8'hAA, 8'h00, 1'b1, '0,
                     128'h0F0E0D0C0B0A09080706050403020100, 10'd16});
      vt.push_back('{"sew32_vl3", 3'd2, 11'd3, 8'h55, 8'h10, 1'b1, '0,
                     128'h555555551B1A19181716151413121110, 10'd12});
      vt.push_back('{"sew16_vl6", 3'd1, 11'd6, 8'h66, 8'h40, 1'b1, '0,
                     128'h666666664B4A49484746454443424140, 10'd12});
      vt.push_back('{"vl0", 3'd1, 11'd0, 8'h33, 8'h00, 1'b1, '0,
                     {16{8'h33}}, 10'd0});
      vt.push_back('{"sew64_vl1", 3'd3, 11'd1, 8'h00, 8'h80, 1'b1, '0,
                     128'h00000000000000008786858483828180, 10'd8});
`ifdef RVV_WB_MASK_EN
      vt.push_back('{"mask_v0", 3'd0, 11'd16, 8'hAA, 8'h00, 1'b0, 128'h5555,
                     128'hAA0EAA0CAA0AAA08AA06AA04AA02AA00, 10'd8});
      vt.push_back('{"mask_vm1", 3'd0, 11'd16, 8'hAA, 8'h00, 1'b1, 128'h5555,
                     128'h0F0E0D0C0B0A09080706050403020100, 10'd16});
`endif

      resetn = 1'b0; start = 1'b0; alu_done = 1'b0; wb_ready = 1'b0; vd_addr = '0;
      vd_old = '0; vsew = '0; vl = '0; vm = 1'b1; v0 = '0;
      lanes(2'b00, '0, '0, '0, '0);
      @(negedge clk);
      step();
      resetn = 1'b1;
      step();
      chk("rst wb_valid", 128'(wb_valid), 128'd0);
      chk("rst wb_addr", 128'(wb_addr), 128'd0);
      chk("rst wb_data", wb_data, 128'd0);
      chk("rst chunk_cnt", 128'(chunk_cnt), 128'd0);
      chk("rst busy", 128'(busy), 128'd0);

      foreach (vt[k]) run_vec(vt[k]);

      // Minimum instruction; start held through WRITE is only taken once back in IDLE.
      start = 1'b1; vd_addr = 5'd3; vd_old = {16{8'h5A}}; vsew = 3'd0; vl = 11'd16;
      step();
      start = 1'b0; alu_done = 1'b1;
      chk("min busy", 128'(busy), 128'd1);
      step();
      alu_done = 1'b0;
      chk("min wb_valid", 128'(wb_valid), 128'd1);
      chk("min wb_data", wb_data, {16{8'h5A}});
      chk("min wb_addr", 128'(wb_addr), 128'd3);
      wb_ready = 1'b1; start = 1'b1; vd_addr = 5'd9; vd_old = {16{8'hC4}};
      step();
      chk("min idle", 128'(busy), 128'd0);
      step();
      start = 1'b0; wb_ready = 1'b0;
      chk("restart busy", 128'(busy), 128'd1);
      alu_done = 1'b1;
      step();
      alu_done = 1'b0;
      chk("restart wb_data", wb_data, {16{8'hC4}});
      chk("restart wb_addr", 128'(wb_addr), 128'd9);

      // Backpressure with a stray start during WRITE.
      start = 1'b1; vd_addr = 5'd1; vd_old = {16{8'h0F}};
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp wb_valid", 128'(wb_valid), 128'd1);
         chk("bp wb_data", wb_data, {16{8'hC4}});
      end
      start = 1'b0; wb_ready = 1'b1;
      step();
      wb_ready = 1'b0;
      chk("bp release valid", 128'(wb_valid), 128'd0);
      chk("bp release busy", 128'(busy), 128'd0);

      // Lane collision, ignored low index bits, out-of-range offset, single-lane valid.
      start = 1'b1; vd_old = '0; vd_addr = 5'd2; vsew = 3'd0; vl = 11'd20;
      step();
      start = 1'b0;
      lanes(2'b11, 10'd0, 10'd0, 8'h11, 8'h22);
      step();
      chk("collide data", wb_data, 128'h22);
      chk("collide cnt", 128'(chunk_cnt), 128'd2);
      lanes(2'b11, 10'd9, 10'd128, 8'h33, 8'h44);
      step();
      chk("range data", wb_data, 128'h3322);
      chk("range cnt", 128'(chunk_cnt), 128'd3);
      lanes(2'b10, 10'd16, 10'd120, 8'h99, 8'h77);
      alu_done = 1'b1;
      step();
      lanes(2'b00, '0, '0, '0, '0); alu_done = 1'b0;
      chk("single wb_valid", 128'(wb_valid), 128'd1);
      chk("single data", wb_data, 128'h77000000000000000000000000003322);
      chk("single cnt", 128'(chunk_cnt), 128'd4);
      wb_ready = 1'b1;
      step();
      wb_ready = 1'b0;

      // Reset mid-COLLECT aborts without writeback.
      start = 1'b1; vd_old = {16{8'h11}}; vl = 11'd16;
      step();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         lanes(2'b01, 10'(8*k), '0, 8'(k+1), '0);
         step();
      end
      lanes(2'b00, '0, '0, '0, '0);
      chk("mid cnt", 128'(chunk_cnt), 128'd3);
      chk("mid data", wb_data, 128'h11111111111111111111111111030201);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      chk("abort wb_valid", 128'(wb_valid), 128'd0);
      chk("abort cnt", 128'(chunk_cnt), 128'd0);
      chk("abort busy", 128'(busy), 128'd0);
      alu_done = 1'b1;
      lanes(2'b11, 10'd0, 10'd8, 8'hEE, 8'hEE);
      step();
      chk("idle ignores done", 128'(wb_valid), 128'd0);
      lanes(2'b00, '0, '0, '0, '0); alu_done = 1'b0;
      start = 1'b1; vd_old = {16{8'hC3}};
      step();
      start = 1'b0; alu_done = 1'b1;
      step();
      alu_done = 1'b0;
      chk("post-reset valid", 128'(wb_valid), 128'd1);
      chk("post-reset data", wb_data, {16{8'hC3}});
      chk("post-reset cnt", 128'(chunk_cnt), 128'd0);
      wb_ready = 1'b1;
      step();
      wb_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
